// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter.
//   OWN_IF / OWN_D   : owner encoding carried in a response tag
//   arb_tag_t        : {valid, owner} tag that travels with each read
//   RAM_LATENCY_MIN/MAX : supported read-latency range
//   flush_tag()      : drops the valid bit of a fetch tag while a flush is active
//   legal_latency()  : pulls a latency parameter into the supported range
package mem_arb_pkg;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } arb_tag_t;

    localparam int TAG_W = $bits(arb_tag_t);

    localparam int RAM_LATENCY_MIN = 1;
    localparam int RAM_LATENCY_MAX = 4;

    function automatic arb_tag_t flush_tag(input arb_tag_t tag, input logic flush);
        arb_tag_t result;
        result = tag;
        if (flush && (tag.owner == OWN_IF)) begin
            result.valid = 1'b0;
        end
        return result;
    endfunction

    function automatic int legal_latency(input int lat);
        if (lat < RAM_LATENCY_MIN) begin
            return RAM_LATENCY_MIN;
        end
        if (lat > RAM_LATENCY_MAX) begin
            return RAM_LATENCY_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/arb_owner_pipe.sv
// Owner-tag delay line. A tag written at grant time appears on tag_out
// DEPTH cycles later, aligned with the RAM read data for that grant.
//   clk      : clock
//   reset_n  : synchronous active-low reset, empties the pipe
//   flush    : invalidates every fetch tag, including the one entering now
//   tag_in   : {valid, owner} of this cycle's grant
//   tag_out  : tag leaving the pipe this cycle
module arb_owner_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    arb_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= flush_tag(arb_tag_t'(tag_in), flush);
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= flush_tag(stage[i-1], flush);
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch (IF) and
// data load/store (D). D wins by default; IF is forced through after
// STARVE_LIMIT consecutive denied cycles. One grant per cycle, read data
// returns RAM_LATENCY cycles later and is steered by an owner tag.
//   clk, reset_n         : clock, synchronous active-low reset
//   if_req/if_addr       : fetch request and byte address
//   if_flush             : discard all in-flight fetch responses
//   if_gnt/if_rvalid/if_rdata : fetch grant and response
//   d_req/d_we/d_be/d_addr/d_wdata : data request
//   d_gnt/d_rvalid/d_rdata : data grant and load response
//   ram_en/ram_we/ram_be/ram_addr/ram_wdata : RAM command (word address)
//   ram_rdata            : RAM read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [ADDR_W-3:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int BE_W       = DATA_W / 8;
    localparam int CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam int PIPE_DEPTH = legal_latency(RAM_LATENCY);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             d_win;
    logic             if_win;
    arb_tag_t         tag_in;
    logic [TAG_W-1:0] tag_out_bits;
    arb_tag_t         tag_out;
    logic             resp_live;

    // Byte offset bits are dropped on purpose; alignment is the core's job.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    // Grants are gated by reset_n so nothing reaches the RAM while in reset.
    always_comb begin
        starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
        d_win   = reset_n & d_req & ~(if_req & starved);
        if_win  = reset_n & if_req & ~d_win;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (if_req && !if_win) begin
            if (!starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (d_win) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_be    = d_we ? d_be : {BE_W{1'b1}};
            ram_addr  = d_addr[ADDR_W-1:2];
            ram_wdata = d_we ? d_wdata : '0;
        end else if (if_win) begin
            ram_en    = 1'b1;
            ram_be    = {BE_W{1'b1}};
            ram_addr  = if_addr[ADDR_W-1:2];
        end
    end

    // Stores finish at grant, so only reads carry a valid tag.
    always_comb begin
        tag_in.valid = if_win | (d_win & ~d_we);
        tag_in.owner = d_win ? OWN_D : OWN_IF;
    end

    arb_owner_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_owner_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (if_flush),
        .tag_in  (tag_in),
        .tag_out (tag_out_bits)
    );

    assign tag_out = arb_tag_t'(tag_out_bits);

    // A fetch response leaving the pipe in the flush cycle is dropped as well.
    always_comb begin
        resp_live = reset_n & tag_out.valid
                  & ~(if_flush & (tag_out.owner == OWN_IF));
        if_rvalid = resp_live & (tag_out.owner == OWN_IF);
        d_rvalid  = resp_live & (tag_out.owner == OWN_D);
        if_rdata  = if_rvalid ? ram_rdata : '0;
        d_rdata   = d_rvalid  ? ram_rdata : '0;
        if_gnt    = if_win;
        d_gnt     = d_win;
    end

endmodule
